// File: rtl/proc_sequencer.sv
// proc_sequencer: multi-cycle fetch/decode/execute sequencer for the Lab 9 datapath.
// Owns PC and IR, fetches over a req/valid handshake, and drives bus-mux and register enables.
`default_nettype none

module proc_sequencer #(
    parameter int             AW         = 8,
    parameter logic [AW-1:0]  START_ADDR = '0
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          RUN,
    output logic          MEM_RD,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_VALID,
    input  logic [8:0]    MEM_DATA,
    input  logic          G_ZERO,
    output logic [9:0]    MUXLINE,
    output logic [9:0]    REGSELECTORS,
    output logic          ADDSUB,
    output logic          DONE,
    output logic          BUSY,
    output logic [AW-1:0] PC,
    output logic [8:0]    IR
);

    localparam logic [AW-1:0] PC_INC  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [2:0]    OP_MV   = 3'b001;
    localparam logic [2:0]    OP_MVI  = 3'b010;
    localparam logic [2:0]    OP_ADD  = 3'b011;
    localparam logic [2:0]    OP_SUB  = 3'b100;
    localparam logic [2:0]    OP_MVNZ = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        IMM    = 3'd4,
        ALU_A  = 3'd5,
        ALU_G  = 3'd6,
        WB     = 3'd7
    } state_t;

    state_t          state;
    logic [AW-1:0]   pc;
    logic [8:0]      ir;
    logic [2:0]      opcode;
    logic [9:0]      x_onehot;
    logic [9:0]      y_onehot;
    state_t          next_instr;

    assign opcode     = ir[8:6];
    assign x_onehot   = 10'b1 << ir[5:3];
    assign y_onehot   = 10'b1 << ir[2:0];
    // RUN is only consulted at IDLE and at the DONE cycle of an instruction.
    assign next_instr = RUN ? FETCH : IDLE;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
            pc    <= START_ADDR;
            ir    <= '0;
        end else begin
            case (state)
                IDLE:   if (RUN) state <= FETCH;
                FETCH: begin
                    if (MEM_VALID) begin
                        ir    <= MEM_DATA;
                        pc    <= pc + PC_INC;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_MVI:         state <= IMM;
                        OP_ADD, OP_SUB: state <= ALU_A;
                        default:        state <= EXEC;
                    endcase
                end
                EXEC:   state <= next_instr;
                IMM: begin
                    if (MEM_VALID) begin
                        pc    <= pc + PC_INC;
                        state <= next_instr;
                    end
                end
                ALU_A:  state <= ALU_G;
                ALU_G:  state <= WB;
                WB:     state <= next_instr;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        MEM_RD       = 1'b0;
        MUXLINE      = '0;
        REGSELECTORS = '0;
        ADDSUB       = 1'b0;
        DONE         = 1'b0;
        case (state)
            FETCH: MEM_RD = 1'b1;
            EXEC: begin
                DONE = 1'b1;
                if (opcode == OP_MV || (opcode == OP_MVNZ && !G_ZERO)) begin
                    MUXLINE      = y_onehot;
                    REGSELECTORS = x_onehot;
                end
            end
            IMM: begin
                MEM_RD = 1'b1;
                if (MEM_VALID) begin
                    MUXLINE      = 10'h200;
                    REGSELECTORS = x_onehot;
                    DONE         = 1'b1;
                end
            end
            ALU_A: begin
                MUXLINE      = x_onehot;
                REGSELECTORS = 10'h100;
            end
            ALU_G: begin
                MUXLINE      = y_onehot;
                REGSELECTORS = 10'h200;
                ADDSUB       = (opcode == OP_ADD);
            end
            WB: begin
                MUXLINE      = 10'h100;
                REGSELECTORS = x_onehot;
                DONE         = 1'b1;
            end
            default: ;
        endcase
    end

    assign BUSY     = (state != IDLE);
    assign MEM_ADDR = pc;
    assign PC       = pc;
    assign IR       = ir;

endmodule

`default_nettype wire

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed self-checking bench for proc_sequencer with a wait-state memory model.
`default_nettype none

module tb_proc_sequencer;

    logic       CLK = 1'b0;
    logic       RESETN, RUN, G_ZERO, MEM_VALID, MEM_RD;
    logic [8:0] MEM_DATA, IR;
    logic [7:0] MEM_ADDR, PC;
    logic [9:0] MUXLINE, REGSELECTORS;
    logic       ADDSUB, DONE, BUSY;

    logic [8:0] mem [0:255];
    int         wait_n;
    int         rd_cnt;
    logic       force_valid;
    int         tests = 0;
    int         fails = 0;

    proc_sequencer #(.AW(8), .START_ADDR(8'd0)) dut (
        .CLK(CLK), .RESETN(RESETN), .RUN(RUN),
        .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_VALID(MEM_VALID), .MEM_DATA(MEM_DATA),
        .G_ZERO(G_ZERO), .MUXLINE(MUXLINE), .REGSELECTORS(REGSELECTORS),
        .ADDSUB(ADDSUB), .DONE(DONE), .BUSY(BUSY), .PC(PC), .IR(IR)
    );

    always #5 CLK = ~CLK;

    // Memory answers after wait_n request cycles; force_valid injects stray valids.
    assign MEM_DATA  = mem[MEM_ADDR];
    assign MEM_VALID = force_valid | (MEM_RD && (rd_cnt >= wait_n));

    always @(posedge CLK) begin
        if (!RESETN || !MEM_RD || MEM_VALID) rd_cnt <= 0;
        else                                 rd_cnt <= rd_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    endtask

    task automatic do_reset();
        RESETN = 1'b0; RUN = 1'b0; G_ZERO = 1'b0; force_valid = 1'b0; wait_n = 0;
        repeat (2) tick();
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        tests++; if (PC !== 8'd0) begin fails++; $display("FAIL reset_pc got %h exp 00", PC); end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        tests++; if ({MEM_RD, DONE, ADDSUB, MUXLINE, REGSELECTORS} !== 23'd0) begin
            fails++; $display("FAIL reset_outputs rd=%b done=%b as=%b mux=%h sel=%h exp all 0",
                              MEM_RD, DONE, ADDSUB, MUXLINE, REGSELECTORS);
        end
        tests++; if (IR !== 9'd0) begin fails++; $display("FAIL reset_ir got %h exp 000", IR); end
        // stray valid while idle must not load anything
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        tests++; if ({BUSY, PC, IR} !== 18'd0) begin
            fails++; $display("FAIL idle_stray_valid busy=%b pc=%h ir=%h exp 0", BUSY, PC, IR);
        end
        RUN = 1'b1;
        tick();
        tests++; if (MEM_RD !== 1'b1 || MEM_ADDR !== 8'd0 || BUSY !== 1'b1) begin
            fails++; $display("FAIL run_fetch rd=%b addr=%h busy=%b exp 1 00 1", MEM_RD, MEM_ADDR, BUSY);
        end
    endtask

    task automatic test_mv();
        clear_mem();
        mem[0] = 9'b001_001_011;
        do_reset();
        RUN = 1'b1;
        tick();
        tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL mv_fetch_done got %b exp 0", DONE); end
        tick();
        RUN = 1'b0;
        tests++; if (REGSELECTORS !== 10'h000) begin fails++; $display("FAIL mv_decode_sel got %h exp 000", REGSELECTORS); end
        tick();
        tests++; if (MUXLINE !== 10'h008 || REGSELECTORS !== 10'h002 || DONE !== 1'b1) begin
            fails++; $display("FAIL mv_exec mux=%h sel=%h done=%b exp 008 002 1", MUXLINE, REGSELECTORS, DONE);
        end
        tests++; if (PC !== 8'd1 || IR !== 9'b001_001_011) begin
            fails++; $display("FAIL mv_pc_ir pc=%h ir=%h exp 01 04b", PC, IR);
        end
        tick();
        tests++; if (BUSY !== 1'b0 || MEM_RD !== 1'b0) begin
            fails++; $display("FAIL mv_idle busy=%b rd=%b exp 0 0", BUSY, MEM_RD);
        end
    endtask

    task automatic test_mvi_wait();
        int cyc = 0, done_cyc = 0, done_cnt = 0, en_cnt = 0, bad_en = 0;
        clear_mem();
        mem[0] = 9'b010_001_000;
        mem[1] = 9'h05A;
        do_reset();
        wait_n = 2;
        RUN = 1'b1;
        while (cyc < 20) begin
            tick();
            cyc++;
            RUN = 1'b0;
            if (REGSELECTORS != 10'h000 || MUXLINE != 10'h000) begin
                en_cnt++;
                if (REGSELECTORS != 10'h002 || MUXLINE != 10'h200 || !MEM_VALID
                    || MEM_ADDR != 8'd1 || MEM_DATA != 9'h05A) bad_en++;
            end
            if (DONE) begin done_cnt++; done_cyc = cyc; end
            if (!BUSY) break;
        end
        tests++; if (done_cyc !== 7) begin fails++; $display("FAIL mvi_latency got %0d exp 7", done_cyc); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL mvi_done_count got %0d exp 1", done_cnt); end
        tests++; if (en_cnt !== 1 || bad_en !== 0) begin
            fails++; $display("FAIL mvi_enables cycles=%0d bad=%0d exp 1 0", en_cnt, bad_en);
        end
        tests++; if (PC !== 8'd2) begin fails++; $display("FAIL mvi_pc got %h exp 02", PC); end
    endtask

    task automatic test_alu(input logic [2:0] op, input logic exp_as);
        clear_mem();
        mem[0] = {op, 3'b011, 3'b010};
        do_reset();
        RUN = 1'b1;
        tick(); tick();
        RUN = 1'b0;
        tick();
        tests++; if (MUXLINE !== 10'h008 || REGSELECTORS !== 10'h100 || ADDSUB !== 1'b0 || DONE !== 1'b0) begin
            fails++; $display("FAIL alu_a op=%b mux=%h sel=%h as=%b done=%b exp 008 100 0 0",
                              op, MUXLINE, REGSELECTORS, ADDSUB, DONE);
        end
        tick();
        tests++; if (MUXLINE !== 10'h004 || REGSELECTORS !== 10'h200 || ADDSUB !== exp_as) begin
            fails++; $display("FAIL alu_g op=%b mux=%h sel=%h as=%b exp 004 200 %b",
                              op, MUXLINE, REGSELECTORS, ADDSUB, exp_as);
        end
        tick();
        tests++; if (MUXLINE !== 10'h100 || REGSELECTORS !== 10'h008 || DONE !== 1'b1 || ADDSUB !== 1'b0) begin
            fails++; $display("FAIL alu_wb op=%b mux=%h sel=%h done=%b as=%b exp 100 008 1 0",
                              op, MUXLINE, REGSELECTORS, DONE, ADDSUB);
        end
        tick();
        tests++; if (BUSY !== 1'b0 || MEM_RD !== 1'b0 || PC !== 8'd1) begin
            fails++; $display("FAIL alu_run_drop op=%b busy=%b rd=%b pc=%h exp 0 0 01", op, BUSY, MEM_RD, PC);
        end
    endtask

    task automatic test_mvnz();
        for (int g = 1; g >= 0; g--) begin
            clear_mem();
            mem[0] = 9'b101_010_101;
            do_reset();
            G_ZERO = g[0];
            RUN = 1'b1;
            tick(); tick();
            RUN = 1'b0;
            tick();
            if (g == 1) begin
                tests++; if (DONE !== 1'b1 || REGSELECTORS !== 10'h000 || MUXLINE !== 10'h000) begin
                    fails++; $display("FAIL mvnz_gzero done=%b sel=%h mux=%h exp 1 000 000", DONE, REGSELECTORS, MUXLINE);
                end
            end else begin
                tests++; if (DONE !== 1'b1 || REGSELECTORS !== 10'h004 || MUXLINE !== 10'h020) begin
                    fails++; $display("FAIL mvnz_gnonzero done=%b sel=%h mux=%h exp 1 004 020", DONE, REGSELECTORS, MUXLINE);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        mem[0] = 9'b011_011_010;
        do_reset();
        RUN = 1'b1;
        repeat (4) tick();
        tests++; if (REGSELECTORS !== 10'h200) begin fails++; $display("FAIL midrst_pre sel=%h exp 200", REGSELECTORS); end
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        RUN = 1'b0;
        tests++; if (BUSY !== 1'b0 || REGSELECTORS !== 10'h000 || PC !== 8'd0 || IR !== 9'd0 || DONE !== 1'b0) begin
            fails++; $display("FAIL midrst busy=%b sel=%h pc=%h ir=%h done=%b exp 0 000 00 000 0",
                              BUSY, REGSELECTORS, PC, IR, DONE);
        end
        // reset during a stalled fetch drops the read
        wait_n = 3;
        RUN = 1'b1;
        tick();
        RESETN = 1'b0;
        RUN = 1'b0;
        tick();
        RESETN = 1'b1;
        tick(); tick();
        tests++; if (BUSY !== 1'b0 || MEM_RD !== 1'b0 || PC !== 8'd0 || IR !== 9'd0) begin
            fails++; $display("FAIL fetch_rst busy=%b rd=%b pc=%h ir=%h exp 0 0 00 000", BUSY, MEM_RD, PC, IR);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int cyc = 0, done_cnt = 0;
        logic seen_b2b = 1'b0;
        clear_mem();
        mem[0]   = 9'h03F;
        mem[255] = 9'b010_111_000;
        do_reset();
        RUN = 1'b1;
        while (cyc < 1200 && done_cnt < 256) begin
            tick();
            cyc++;
            if (done_cnt == 1 && !seen_b2b) begin
                seen_b2b = 1'b1;
                tests++; if (MEM_RD !== 1'b1 || MEM_ADDR !== 8'd1) begin
                    fails++; $display("FAIL b2b_fetch rd=%b addr=%h exp 1 01", MEM_RD, MEM_ADDR);
                end
            end
            if (DONE) begin
                done_cnt++;
                if (done_cnt == 256) begin
                    RUN = 1'b0;
                    tests++; if (MEM_ADDR !== 8'd0 || IR !== 9'b010_111_000 || MUXLINE !== 10'h200
                                 || REGSELECTORS !== 10'h080) begin
                        fails++; $display("FAIL wrap_imm addr=%h ir=%h mux=%h sel=%h exp 00 0b8 200 080",
                                          MEM_ADDR, IR, MUXLINE, REGSELECTORS);
                    end
                end
            end
        end
        tests++; if (done_cnt !== 256 || cyc !== 768) begin
            fails++; $display("FAIL wrap_count dones=%0d cycles=%0d exp 256 768", done_cnt, cyc);
        end
        tick();
        tests++; if (PC !== 8'd1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL wrap_pc pc=%h busy=%b exp 01 0", PC, BUSY);
        end
    endtask

    initial begin
        RESETN = 1'b0; RUN = 1'b0; G_ZERO = 1'b0; force_valid = 1'b0; wait_n = 0;
        clear_mem();
        test_reset();
        test_mv();
        test_mvi_wait();
        test_alu(3'b011, 1'b1);
        test_alu(3'b100, 1'b0);
        test_mvnz();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
